// File: rtl/midi_uart_rx.sv
// midi_uart_rx
// -----------------------------------------------------------------------------
// MIDI input-port receiver: 8N1, idle-high asynchronous line to parallel bytes.
// The line is oversampled 16x and each bit is decided by a 3-sample majority
// taken around the middle of the bit.
//
// Parameters:
//   CLK_FREQ  CLK frequency in Hz
//   BAUD      line bit rate (31 250 for MIDI)
//
// Ports:
//   CLK   in   system clock
//   RST   in   synchronous active-high reset
//   CE    in   clock enable of the downstream consumer (only clears DV)
//   RX    in   asynchronous serial line, idle high
//   DATA  out  last correctly framed byte, held until the next good byte
//   DV    out  new byte available, held until the first CE-qualified edge
//   FERR  out  one-CLK pulse on a stop-bit framing error
//   BUSY  out  high while a frame is in progress (START, BITS, STOP)
// -----------------------------------------------------------------------------
module midi_uart_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 31_250
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CE,
  input  logic       RX,
  output logic [7:0] DATA,
  output logic       DV,
  output logic       FERR,
  output logic       BUSY
);

  localparam int DIV = CLK_FREQ / (16 * BAUD);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  // A divider below 2 cannot produce distinct oversampling ticks.
  if (DIV < 2) begin : g_div_check
    $error("midi_uart_rx: CLK_FREQ/(16*BAUD) must be at least 2");
  end

  typedef enum logic [2:0] {
    S_WAIT_IDLE = 3'd0,
    S_IDLE      = 3'd1,
    S_START     = 3'd2,
    S_BITS      = 3'd3,
    S_STOP      = 3'd4
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic [1:0]    sync_r;
  logic          rx_s;
  state_t        state_r;
  logic [DW-1:0] div_cnt_r;
  logic [3:0]    sc_r;
  logic [2:0]    bit_idx_r;
  logic [7:0]    shift_r;
  logic [1:0]    samp_r;     // samples taken at sc = 7 and sc = 8
  logic          tick_s;
  logic          decide_s;
  logic          bit_end_s;
  logic          maj_s;

  // Two-stage synchronizer for the asynchronous line, resetting to idle-high.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], RX};
    end
  end

  assign rx_s      = sync_r[1];
  assign tick_s    = (div_cnt_r == DIV_LAST);
  assign decide_s  = tick_s && (sc_r == 4'd9);
  assign bit_end_s = tick_s && (sc_r == 4'd15);
  // Third vote is the live sample at the sc = 9 tick.
  assign maj_s     = maj3(samp_r[0], samp_r[1], rx_s);

  // Frame FSM with oversampling counters and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r   <= S_WAIT_IDLE;
      div_cnt_r <= {DW{1'b0}};
      sc_r      <= 4'd0;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
      samp_r    <= 2'b00;
      DATA      <= 8'h00;
      DV        <= 1'b0;
      FERR      <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      FERR <= 1'b0;

      if (tick_s) begin
        div_cnt_r <= {DW{1'b0}};
        sc_r      <= sc_r + 4'd1;
        if (sc_r == 4'd7) begin
          samp_r[0] <= rx_s;
        end
        if (sc_r == 4'd8) begin
          samp_r[1] <= rx_s;
        end
      end else begin
        div_cnt_r <= div_cnt_r + DW'(1);
      end

      // A set in the STOP branch below overrides this clear on the same edge.
      if (CE) begin
        DV <= 1'b0;
      end

      case (state_r)
        S_WAIT_IDLE: begin
          if (rx_s) begin
            state_r <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (!rx_s) begin
            // Restart the divider so the tick phase follows the start edge.
            state_r   <= S_START;
            sc_r      <= 4'd0;
            div_cnt_r <= {DW{1'b0}};
            BUSY      <= 1'b1;
          end
        end
        S_START: begin
          if (decide_s && maj_s) begin
            state_r <= S_IDLE;
            BUSY    <= 1'b0;
          end else if (bit_end_s) begin
            state_r   <= S_BITS;
            bit_idx_r <= 3'd0;
          end
        end
        S_BITS: begin
          if (decide_s) begin
            shift_r <= {maj_s, shift_r[7:1]};
          end
          if (bit_end_s) begin
            if (bit_idx_r == 3'd7) begin
              state_r <= S_STOP;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end
        end
        S_STOP: begin
          // Leave at mid stop bit so a back-to-back start edge is not missed.
          if (decide_s) begin
            BUSY <= 1'b0;
            if (maj_s) begin
              DATA    <= shift_r;
              DV      <= 1'b1;
              state_r <= S_IDLE;
            end else begin
              FERR    <= 1'b1;
              state_r <= S_WAIT_IDLE;
            end
          end
        end
        default: begin
          state_r <= S_WAIT_IDLE;
          BUSY    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_midi_uart_rx.sv
// tb_midi_uart_rx
// -----------------------------------------------------------------------------
// Self-checking bench for midi_uart_rx at CLK_FREQ = 8 MHz (DIV = 16, 256 CLK
// per bit). Frames are driven bit by bit; a monitor records DV/FERR activity
// and a frame-level model (good stop -> byte delivered, bad stop -> one FERR)
// supplies the expected results.
// -----------------------------------------------------------------------------
module tb_midi_uart_rx;

  localparam int BIT_CLK = 256;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       CE  = 1'b1;
  logic       RX  = 1'b1;
  logic [7:0] DATA;
  logic       DV;
  logic       FERR;
  logic       BUSY;

  midi_uart_rx #(.CLK_FREQ(8_000_000), .BAUD(31_250)) dut (
    .CLK (CLK),
    .RST (RST),
    .CE  (CE),
    .RX  (RX),
    .DATA(DATA),
    .DV  (DV),
    .FERR(FERR),
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // Monitor state (written only by the monitor process).
  int         cyc = 0;
  int         got_cnt = 0;
  logic [7:0] got_mem [0:63];
  int         dv_rise_cyc = 0;
  int         cur_len = 0;
  int         last_len = 0;
  logic       fall_ce = 1'b0;
  int         dv_early = 0;
  int         dv_late = 0;
  int         ferr_cyc = 0;
  int         ferr_pulses = 0;
  logic       dv_q = 1'b0;
  logic       ferr_q = 1'b0;
  int         ce_cnt = 0;
  logic       ce_mode = 1'b0;    // written by the main sequence only

  // Monitor: captures DV/FERR events and generates CE.
  always @(negedge CLK) begin
    cyc    <= cyc + 1;
    dv_q   <= DV;
    ferr_q <= FERR;
    if (DV && !dv_q) begin
      if (got_cnt < 64) got_mem[got_cnt] <= DATA;
      got_cnt     <= got_cnt + 1;
      dv_rise_cyc <= cyc;
      cur_len     <= 1;
    end else if (DV) begin
      cur_len <= cur_len + 1;
    end
    if (!DV && dv_q) begin
      last_len <= cur_len;
      fall_ce  <= CE;
    end
    // CE here is the value the DUT saw at the edge just passed.
    if (dv_q && !DV && !CE) dv_early <= dv_early + 1;
    if (dv_q && DV && CE)   dv_late  <= dv_late + 1;
    if (FERR)               ferr_cyc <= ferr_cyc + 1;
    if (FERR && !ferr_q)    ferr_pulses <= ferr_pulses + 1;
    CE     <= ce_mode ? (ce_cnt % 4 == 0) : 1'b1;
    ce_cnt <= ce_cnt + 1;
  end

  // Checker bookkeeping and reference model (main sequence only).
  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_mem [0:63];
  int         exp_cnt = 0;
  int         exp_ferr = 0;
  logic [7:0] last_good = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    total++;
    assert (obs >= lo && obs <= hi) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Frame-level model: a high stop bit delivers the byte, a low one is a framing error.
  task automatic model_frame(input logic [7:0] d, input logic stop);
    if (stop) begin
      exp_mem[exp_cnt] = d;
      exp_cnt++;
      last_good = d;
    end else begin
      exp_ferr++;
    end
  endtask

  task automatic send_bit(input logic b);
    RX = b;
    repeat (BIT_CLK) @(negedge CLK);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
    model_frame(d, stop);
  endtask

  initial begin
    int         g0;
    int         t0;
    int         f0;
    logic [7:0] rd;
    logic       rs;
    int         gap;
    logic [7:0] a5;

    @(negedge CLK);
    repeat (4) @(negedge CLK);
    chk("rst_data", DATA, 8'h00);
    chk("rst_dv", DV, 1'b0);
    chk("rst_ferr", FERR, 1'b0);
    chk("rst_busy", BUSY, 1'b0);
    RST = 1'b0;
    repeat (2 * BIT_CLK) @(negedge CLK);

    // Single byte, latency and pulse width.
    g0 = got_cnt;
    t0 = cyc;
    send_frame(8'h90, 1'b1);
    repeat (20) @(negedge CLK);
    chk("t1_dv_count", got_cnt - g0, 1);
    chk("t1_data", DATA, 8'h90);
    chk_rng("t1_latency", dv_rise_cyc - t0, 2461, 2473);
    chk("t1_dv_len", last_len, 1);
    chk("t1_ferr", ferr_pulses, 0);
    chk("t1_busy", BUSY, 1'b0);

    // Back-to-back frames with no idle gap.
    g0 = got_cnt;
    send_frame(8'h90, 1'b1);
    send_frame(8'h3C, 1'b1);
    send_frame(8'h7F, 1'b1);
    repeat (20) @(negedge CLK);
    chk("t2_dv_count", got_cnt - g0, 3);
    chk("t2_data", DATA, 8'h7F);
    chk("t2_ferr", ferr_pulses, 0);

    // Sparse CE: DV must wait for the first CE-qualified edge.
    ce_mode = 1'b1;
    g0 = got_cnt;
    send_frame(8'hC5, 1'b1);
    repeat (20) @(negedge CLK);
    chk("t3_dv_count", got_cnt - g0, 1);
    chk_rng("t3_dv_len", last_len, 1, 4);
    chk("t3_fall_on_ce", fall_ce, 1'b1);
    chk("t3_dv_early", dv_early, 0);
    chk("t3_dv_late", dv_late, 0);
    chk("t3_data", DATA, 8'hC5);
    ce_mode = 1'b0;
    repeat (8) @(negedge CLK);

    // Short low glitch is rejected.
    g0 = got_cnt;
    f0 = ferr_pulses;
    RX = 1'b0;
    repeat (50) @(negedge CLK);
    chk("t4_busy_in_start", BUSY, 1'b1);
    repeat (50) @(negedge CLK);
    RX = 1'b1;
    repeat (100) @(negedge CLK);
    chk("t4_busy_cleared", BUSY, 1'b0);
    repeat (3 * BIT_CLK) @(negedge CLK);
    chk("t4_no_dv", got_cnt - g0, 0);
    chk("t4_no_ferr", ferr_pulses - f0, 0);

    // Framing error followed by a held-low line (break), then a good byte.
    g0 = got_cnt;
    send_frame(8'h55, 1'b0);
    RX = 1'b0;
    repeat (2000) @(negedge CLK);
    RX = 1'b1;
    repeat (2 * BIT_CLK) @(negedge CLK);
    chk("t5_ferr_pulses", ferr_pulses, exp_ferr);
    chk("t5_ferr_width", ferr_cyc, exp_ferr);
    chk("t5_no_dv", got_cnt - g0, 0);
    chk("t5_data_kept", DATA, 8'hC5);
    send_frame(8'hFF, 1'b1);
    repeat (20) @(negedge CLK);
    chk("t5_next_data", DATA, 8'hFF);
    chk("t5_next_count", got_cnt - g0, 1);

    // Reset in the middle of 8'hA5; released while the line is low.
    a5 = 8'hA5;
    g0 = got_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(a5[i]);
    RX = a5[4];
    repeat (100) @(negedge CLK);
    RST = 1'b1;
    repeat (4) @(negedge CLK);
    chk("t6_rst_data", DATA, 8'h00);
    chk("t6_rst_dv", DV, 1'b0);
    chk("t6_rst_ferr", FERR, 1'b0);
    chk("t6_rst_busy", BUSY, 1'b0);
    repeat (BIT_CLK - 104) @(negedge CLK);
    send_bit(a5[5]);
    RX = a5[6];
    repeat (BIT_CLK / 2) @(negedge CLK);
    RST = 1'b0;
    repeat (BIT_CLK / 2) @(negedge CLK);
    send_bit(a5[7]);
    send_bit(1'b1);
    last_good = 8'h00;
    repeat (3 * BIT_CLK) @(negedge CLK);
    chk("t6_no_dv", got_cnt - g0, 0);
    chk("t6_busy_idle", BUSY, 1'b0);
    send_frame(8'h12, 1'b1);
    repeat (20) @(negedge CLK);
    chk("t6_next_data", DATA, 8'h12);
    chk("t6_next_count", got_cnt - g0, 1);

    // Randomized frames: random data, mostly good stop bits, random idle gaps.
    for (int i = 0; i < 6; i++) begin
      rd  = 8'($urandom_range(0, 255));
      rs  = ($urandom_range(0, 3) != 0);
      gap = rs ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
      send_frame(rd, rs);
      RX = 1'b1;
      repeat (gap * BIT_CLK) @(negedge CLK);
    end
    repeat (3 * BIT_CLK) @(negedge CLK);

    // Whole-run comparison against the model.
    chk("all_dv_count", got_cnt, exp_cnt);
    for (int i = 0; i < exp_cnt; i++) chk($sformatf("byte_%0d", i), got_mem[i], exp_mem[i]);
    chk("all_ferr_pulses", ferr_pulses, exp_ferr);
    chk("all_ferr_width", ferr_cyc, exp_ferr);
    chk("all_dv_early", dv_early, 0);
    chk("all_dv_late", dv_late, 0);
    chk("final_data", DATA, last_good);
    chk("final_busy", BUSY, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/midi_uart_rx.md
# midi_uart_rx

Serial receiver for the MIDI input port. Converts the asynchronous 31 250 baud line (8N1, idle high) into bytes on DATA with a DV strobe. It sits directly upstream of the MIDI message state machine. DV is stretched until the first CE-qualified clock, so the clock-enabled FSM always sees every byte. DATA stays stable until the next byte completes, so the FSM can re-read it one CE cycle later.

## Interface
- CLK_FREQ, 50_000_000: CLK frequency in Hz.
- BAUD, 31_250: line bit rate.
- Derived DIV = CLK_FREQ / (16*BAUD), truncated. Elaboration must fail if DIV < 2. Default DIV = 100.

- CLK  in  1  system clock.
- RST  in  1  reset, synchronous, active-high; clock CLK.
- CE  in  1  clock enable of the downstream consumer. Used only for DV clearing; the receiver itself runs every CLK.
- RX  in  1  asynchronous serial line, idle high.
- DATA  out  8  last correctly framed byte; held until the next good byte.
- DV  out  1  new byte available; cleared by the consumer's CE.
- FERR  out  1  one-CLK pulse on a stop-bit framing error.
- BUSY  out  1  high while a frame is in progress (START, BITS, STOP).

## Operation
- **Input synchronizer:** RX passes through a 2-FF synchronizer (rx_s). Both FFs reset to 1.
- **Tick generator:** counter 0..DIV-1 produces a one-CLK tick at count DIV-1, giving 16 ticks per bit.
  - The counter is zeroed on entry to START so the phase aligns with the start edge.
- **Sample counter:** sc, 0..15, advances on each tick.
- **Bit sampling:** majority of rx_s taken at sc = 7, 8, 9. The bit decision is made at sc = 9.
- **States:**
  - WAIT_IDLE: the reset state. Go to IDLE when rx_s = 1.
  - IDLE: on rx_s = 0, go to START with sc = 0 and the divider cleared.
  - START: at the sc = 9 decision:
    - majority 1 → glitch; return to IDLE, no output.
    - majority 0 → when sc reaches 15, go to BITS with bit index 0.
  - BITS: at each sc = 9 decision, shift the majority into a shift register, LSB first. After bit 7's sc = 15, go to STOP.
  - STOP: at the sc = 9 decision:
    - majority 1 → DATA <= shift register, DV <= 1, go to IDLE.
    - majority 0 → FERR pulses for one CLK, DATA unchanged, go to WAIT_IDLE. This covers break and a line held low.
- **DV clearing:** DV is cleared on the first CLK edge with CE = 1 that occurs after the edge that set it.
  - If a new byte sets DV on the same edge that CE would clear it, the set wins.
- **Overrun:** a new good byte arriving while DV = 1 overwrites DATA; DV stays 1. No overrun flag.
- **BUSY** = 1 in START, BITS and STOP.
- **Reset values:** DATA = 8'h00, DV = 0, FERR = 0, BUSY = 0, state WAIT_IDLE, counters 0, shift register 0.
- **RST mid-frame:** the frame is abandoned. The receiver waits for the line to return high before accepting a new start bit, so there is no false start on a line that is already low.

## Timing
- The start edge is seen 2–3 CLK after the RX fall (synchronizer).
- One bit = 16*DIV CLK.
- Data bit n is decided 16*DIV*(n+1) + 10*DIV − 1 CLK after START entry (±1 CLK).
- DV rises on the CLK after the stop-bit decision, i.e. about 9.6 bit times (≈ 307 µs at default) after the RX falling edge.
- With CE held at 1, DV is high for exactly 1 CLK.
- Back-to-back frames are supported: the receiver returns to IDLE at the middle of the stop bit and re-arms for the next start edge.
- Tolerated baud mismatch: ±3 % cumulative.

## Test plan
Bench parameters: CLK_FREQ = 8_000_000, BAUD = 31_250, giving DIV = 16 and 256 CLK per bit. CE = 1 unless stated otherwise.
1. Send 8'h90 with a stop bit → DATA = 8'h90, DV high for 1 CLK about 2460 CLK after the start edge; FERR = 0; BUSY low after DV.
2. Send 8'h90, 8'h3C, 8'h7F back-to-back with no idle gap → three DV pulses with DATA = 90, 3C, 7F in order; no FERR.
3. CE pulses every 4th CLK; send 8'hC5 → DV stays high until the first CE = 1 edge, then clears. DATA = C5 remains after DV clears.
4. RX low pulse of 100 CLK (shorter than half a bit) → no DV, no FERR; BUSY returns low by sc = 9 of START.
5. Send 8'h55 with stop bit = 0, then hold RX low for 2000 CLK, then release → one FERR pulse, DATA keeps its previous value, no DV. A following 8'hFF is received correctly.
6. Assert RST at bit 4 of 8'hA5 while RX continues the frame → outputs at reset values. The remaining bits of the frame do not produce a DV. The next full frame 8'h12 yields DATA = 12.
